activation_writer: RTL and testbench



---
 rtl/activation_writer_if.sv | 26 ++
 rtl/activation_writer.sv | 81 ++++++++
 tb/tb_activation_writer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/activation_writer_if.sv
// Handshake and BRAM write-port bundle for activation_writer.
// master = requester side (drives start/data_in), slave = the writer itself.
interface activation_writer_if #(
  parameter int unsigned NUM_WORDS  = 1152,
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                      start;
  logic [NUM_WORDS*W-1:0]    data_in;
  logic                      bram_en;
  logic                      bram_wen;
  logic [ADDR_WIDTH-1:0]     bram_addr;
  logic [W-1:0]              bram_din;
  logic                      busy;
  logic                      done;

  modport master (
    output start, data_in,
    input  bram_en, bram_wen, bram_addr, bram_din, busy, done
  );

  modport slave (
    input  start, data_in,
    output bram_en, bram_wen, bram_addr, bram_din, busy, done
  );
endinterface

// File: rtl/activation_writer.sv
// Streams a NUM_WORDS x W snapshot into consecutive BRAM addresses, one word per cycle,
// starting at BASE_ADDR; all BRAM-side outputs are registered.
module activation_writer #(
  parameter int unsigned NUM_WORDS  = 1152,
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned BASE_ADDR  = 119808
) (
  input  logic               clk,
  input  logic               rst_n,
  activation_writer_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(NUM_WORDS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_WORDS*W-1:0]  snap_q, snap_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [W-1:0]            din_q, din_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          state_d = StWrite;
          cnt_d   = '0;
          addr_d  = BaseAddr;
          din_d   = bus_io.data_in[W-1:0];
          // Snapshot keeps only the words not yet presented; word 0 goes straight out.
          snap_d  = bus_io.data_in >> W;
        end
      end
      StWrite: begin
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
          din_d  = snap_q[W-1:0];
          snap_d = snap_q >> W;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      snap_q  <= '0;
      addr_q  <= BaseAddr;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // Strobes and status decode straight from the registered state, so they drop with reset.
  assign bus_io.bram_en   = (state_q == StWrite);
  assign bus_io.bram_wen  = (state_q == StWrite);
  assign bus_io.busy      = (state_q == StWrite);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.bram_addr = addr_q;
  assign bus_io.bram_din  = din_q;

endmodule

// File: tb/tb_activation_writer.sv
// Self-checking bench for activation_writer: table vectors, random transfers, wrap,
// single-word and mid-transfer reset sequences against a BRAM/address model.
module tb_activation_writer;

  localparam int unsigned NW    = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 18;
  localparam int unsigned BASE  = 100;
  localparam int unsigned WBASE = 262142;

  typedef struct {
    logic          en;
    logic          wen;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [W-1:0]  din;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  e0, e1, e2, e3;
    int          disturb;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   strobes [3] = '{0, 0, 0};
  logic [W-1:0] mem_a [int unsigned];
  obs_t mon_o;

  activation_writer_if #(.NUM_WORDS(NW), .W(W), .ADDR_WIDTH(AW)) bus_a ();
  activation_writer_if #(.NUM_WORDS(NW), .W(W), .ADDR_WIDTH(AW)) bus_w ();
  activation_writer_if #(.NUM_WORDS(1),  .W(W), .ADDR_WIDTH(AW)) bus_s ();

  activation_writer #(.NUM_WORDS(NW), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus_io(bus_a)
  );
  activation_writer #(.NUM_WORDS(NW), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(WBASE)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .bus_io(bus_w)
  );
  activation_writer #(.NUM_WORDS(1), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus_io(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0: begin
        o.en = bus_a.bram_en; o.wen = bus_a.bram_wen; o.busy = bus_a.busy;
        o.done = bus_a.done; o.addr = bus_a.bram_addr; o.din = bus_a.bram_din;
      end
      1: begin
        o.en = bus_w.bram_en; o.wen = bus_w.bram_wen; o.busy = bus_w.busy;
        o.done = bus_w.done; o.addr = bus_w.bram_addr; o.din = bus_w.bram_din;
      end
      default: begin
        o.en = bus_s.bram_en; o.wen = bus_s.bram_wen; o.busy = bus_s.busy;
        o.done = bus_s.done; o.addr = bus_s.bram_addr; o.din = bus_s.bram_din;
      end
    endcase
    return o;
  endfunction

  task automatic set_in(input int d, input logic s, input logic [31:0] data);
    case (d)
      0:       begin bus_a.start = s; bus_a.data_in = data; end
      1:       begin bus_w.start = s; bus_w.data_in = data; end
      default: begin bus_s.start = s; bus_s.data_in = data[7:0]; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word i is the i-th base-256 digit of data_in; addresses wrap mod 2^AW.
  function automatic logic [7:0] model_word(input logic [31:0] data, input int i);
    return 8'((data / (32'd1 << (8 * i))) % 256);
  endfunction

  function automatic logic [AW-1:0] model_addr(input int unsigned base, input int i);
    return AW'((base + i) % (32'd1 << AW));
  endfunction

  // Every write strobe seen at a falling edge lands in the BRAM model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      mon_o = get_obs(d);
      checks++;
      if (mon_o.wen && !mon_o.en) begin
        errors++;
        $display("FAIL wen_without_en: dut %0d got wen=1 en=0 required wen=0", d);
      end
      if (mon_o.en && mon_o.wen) begin
        strobes[d]++;
        if (d == 0) mem_a[int'(mon_o.addr)] = mon_o.din;
      end
    end
  end

  // Starts at a falling edge; ends at the falling edge after the DONE transition.
  task automatic xfer(input int d, input logic [31:0] data, input logic [31:0] expw,
                      input int disturb);
    int          nw;
    int unsigned base;
    int          s0;
    logic [31:0] cur;
    obs_t        o;
    nw   = (d == 2) ? 1 : NW;
    base = (d == 1) ? WBASE : BASE;
    s0   = strobes[d];
    cur  = data;
    set_in(d, 1'b1, cur);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      o = get_obs(d);
      chk("write_flags", {28'd0, o.en, o.wen, o.busy, o.done}, 32'b1110);
      chk("write_addr", 32'(o.addr), 32'(model_addr(base, i)));
      chk("write_din", 32'(o.din), 32'(expw[8*i +: 8]));
      if (i == disturb) cur = 32'h0;
      set_in(d, (i == disturb), cur);
    end
    @(negedge clk);
    set_in(d, 1'b0, cur);
    o = get_obs(d);
    chk("done_flags", {28'd0, o.en, o.wen, o.busy, o.done}, 32'b0001);
    chk("strobe_count", 32'(strobes[d] - s0), 32'(nw));
    if (d == 0) begin
      for (int i = 0; i < nw; i++) begin
        int unsigned a;
        a = int'(model_addr(base, i));
        chk("bram_model", mem_a.exists(a) ? 32'(mem_a[a]) : 32'hFFFF_FFFF,
            32'(expw[8*i +: 8]));
      end
    end
  endtask

  initial begin
    vec_t        tbl [4];
    obs_t        o;
    logic [31:0] rdata;
    logic [31:0] rexp;
    int          s0;

    tbl[0] = '{32'hDDCCBBAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD, -1};
    tbl[1] = '{32'hDDCCBBAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1};
    tbl[2] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44, -1};
    tbl[3] = '{32'h0F1E2D3C, 8'h3C, 8'h2D, 8'h1E, 8'h0F, 0};

    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      o = get_obs(d);
      chk("reset_flags", {28'd0, o.en, o.wen, o.busy, o.done}, 32'b0000);
      chk("reset_addr", 32'(o.addr), (d == 1) ? WBASE : BASE);
      chk("reset_din", 32'(o.din), 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle hold: nothing happens without start.
    repeat (20) begin
      @(negedge clk);
      o = get_obs(0);
      chk("idle_hold", {29'd0, o.en, o.busy, o.done}, 32'b000);
    end

    // Table vectors run back-to-back: each starts from the previous DONE.
    for (int i = 0; i < 4; i++) begin
      xfer(0, tbl[i].data, {tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0}, tbl[i].disturb);
    end

    repeat (3) begin
      @(negedge clk);
      o = get_obs(0);
      chk("done_hold", {28'd0, o.en, o.wen, o.busy, o.done}, 32'b0001);
    end

    for (int r = 0; r < 8; r++) begin
      rdata = $urandom;
      for (int i = 0; i < 4; i++) rexp[8*i +: 8] = model_word(rdata, i);
      xfer(0, rdata, rexp, int'($urandom_range(0, 3)) - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Address wrap past all-ones.
    rdata = 32'h04030201;
    for (int i = 0; i < 4; i++) rexp[8*i +: 8] = model_word(rdata, i);
    xfer(1, rdata, rexp, -1);

    // Single-word configuration.
    xfer(2, 32'h0000005A, 32'h0000005A, -1);

    // Reset mid-transfer after two writes.
    mem_a.delete();
    s0 = strobes[0];
    set_in(0, 1'b1, 32'hDDCCBBAA);
    @(negedge clk);
    set_in(0, 1'b0, 32'hDDCCBBAA);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    o = get_obs(0);
    chk("abort_flags", {28'd0, o.en, o.wen, o.busy, o.done}, 32'b0000);
    chk("abort_addr", 32'(o.addr), BASE);
    chk("abort_din", 32'(o.din), 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_strobes", 32'(strobes[0] - s0), 32'd2);
    chk("abort_mem_size", 32'(mem_a.size()), 32'd2);
    chk("abort_mem_100", mem_a.exists(100) ? 32'(mem_a[100]) : 32'hFFFF_FFFF, 32'hAA);
    chk("abort_mem_101", mem_a.exists(101) ? 32'(mem_a[101]) : 32'hFFFF_FFFF, 32'hBB);
    rst_n = 1'b1;
    @(negedge clk);
    rdata = 32'h87654321;
    for (int i = 0; i < 4; i++) rexp[8*i +: 8] = model_word(rdata, i);
    xfer(0, rdata, rexp, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
